// File: rtl/asrm_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// asrm_rx_fifo_pkg
// Shared constants for the byte-wide receive FIFO peripheral:
//   - register offsets relative to base_addr
//   - bit positions inside the status vector
//   - bit positions inside the CTRL write word
//   - a small helper that saturates the occupancy count into a 4-bit field
// -----------------------------------------------------------------------------
package asrm_rx_fifo_pkg;

  // Register offsets from base_addr
  localparam int unsigned DATA_OFS   = 0;
  localparam int unsigned CTRL_OFS   = 1;

  // Status vector bit positions
  localparam int unsigned ST_NEMPTY  = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_UDF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  // CTRL write-word bit positions
  localparam int unsigned CT_CLR_OVF = 0;
  localparam int unsigned CT_CLR_UDF = 1;
  localparam int unsigned CT_FLUSH   = 2;

  // Occupancy can reach 128 entries; the status field only has 4 bits.
  function automatic logic [3:0] sat_cnt4(input logic [7:0] cnt);
    logic [3:0] res;
    if (cnt > 8'd15) begin
      res = 4'hF;
    end else begin
      res = cnt[3:0];
    end
    return res;
  endfunction

endpackage : asrm_rx_fifo_pkg

// File: rtl/asrm_fifo_mem.sv
// -----------------------------------------------------------------------------
// asrm_fifo_mem
// 2^depth_log2 x 8 storage array for the receive FIFO.
// Synchronous write port, asynchronous (combinational) read port so the head
// byte is available in the same cycle a pop is decided.
// Contents are not reset; the controller never reads an entry it has not
// written since reset or flush.
// Ports:
//   clk      - system clock
//   wr_en    - write strobe
//   wr_addr  - write index (tail pointer)
//   wr_data  - byte to store
//   rd_addr  - read index (head pointer)
//   rd_data  - byte at rd_addr
// -----------------------------------------------------------------------------
module asrm_fifo_mem #(
  parameter int unsigned depth_log2 = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [depth_log2-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [depth_log2-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  localparam int unsigned DEPTH = 1 << depth_log2;

  logic [7:0] mem_q [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : asrm_fifo_mem

// File: rtl/asrm_rx_fifo.sv
// -----------------------------------------------------------------------------
// asrm_rx_fifo
// Byte-wide receive FIFO between a serial receiver and the system bus.
//   DATA register (base_addr)   : pop-on-read, registered data_out, 0 when idle
//   CTRL register (base_addr+1) : write-only; bit0 clear overflow,
//                                 bit1 clear underflow, bit2 flush
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   enable    - bus access strobe
//   addr      - bus address
//   write_en  - 1 = write, 0 = read
//   data_in   - bus write data
//   data_out  - registered bus read data (one-cycle latency)
//   push      - receiver byte-valid strobe
//   push_data - received byte
//   status    - {count_sat[3:0], underflow, overflow, full, not_empty}
//   irq       - (only with ASRM_RX_FIFO_IRQ_EN) registered not_empty | overflow
// Optional feature macro: ASRM_RX_FIFO_IRQ_EN
// -----------------------------------------------------------------------------
module asrm_rx_fifo
  import asrm_rx_fifo_pkg::*;
#(
  parameter int unsigned addr_size  = 16,
  parameter int unsigned base_addr  = 0,
  parameter int unsigned depth_log2 = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [addr_size-1:0] addr,
  input  logic                 write_en,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic                 push,
  input  logic [7:0]           push_data,
  output logic [7:0]           status
`ifdef ASRM_RX_FIFO_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int unsigned DEPTH = 1 << depth_log2;
  localparam int unsigned CW    = depth_log2 + 1;

  localparam logic [addr_size-1:0] DATA_ADDR = addr_size'(base_addr + DATA_OFS);
  localparam logic [addr_size-1:0] CTRL_ADDR = addr_size'(base_addr + CTRL_OFS);

  // Registered state
  logic [depth_log2-1:0] head_q, head_d;
  logic [depth_log2-1:0] tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_prev_q, rd_prev_d;
  logic [7:0]            data_out_q, data_out_d;

  // Decode and control strobes
  logic       rd_data_s;
  logic       wr_ctrl_s;
  logic       rd_first_s;
  logic       empty_s;
  logic       full_s;
  logic       flush_s;
  logic       clr_ovf_s;
  logic       clr_udf_s;
  logic       pop_s;
  logic       push_ok_s;
  logic       ovf_set_s;
  logic       udf_set_s;
  logic [7:0] head_byte_s;
  logic [7:0] status_s;

  asrm_fifo_mem #(
    .depth_log2 (depth_log2)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok_s),
    .wr_addr (tail_q),
    .wr_data (push_data),
    .rd_addr (head_q),
    .rd_data (head_byte_s)
  );

  // Bus decode and push/pop arbitration
  always_comb begin
    rd_data_s  = enable && !write_en && (addr == DATA_ADDR);
    wr_ctrl_s  = enable &&  write_en && (addr == CTRL_ADDR);
    // Only the leading cycle of a read access pops; a held strobe reads once.
    rd_first_s = rd_data_s && !rd_prev_q;
    empty_s    = (count_q == {CW{1'b0}});
    full_s     = (count_q == CW'(DEPTH));
    flush_s    = wr_ctrl_s && data_in[CT_FLUSH];
    clr_ovf_s  = wr_ctrl_s && data_in[CT_CLR_OVF];
    clr_udf_s  = wr_ctrl_s && data_in[CT_CLR_UDF];
    pop_s      = rd_first_s && !empty_s && !flush_s;
    udf_set_s  = rd_first_s && empty_s && !flush_s;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
    push_ok_s  = push && !flush_s && (!full_s || pop_s);
    ovf_set_s  = push && !flush_s && full_s && !pop_s;
  end

  // Next-state for pointers, count, sticky flags and read data
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rd_prev_d  = rd_data_s;
    data_out_d = 8'h00;

    if (flush_s) begin
      head_d  = {depth_log2{1'b0}};
      tail_d  = {depth_log2{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        head_d = head_q + depth_log2'(1);
      end else begin
        head_d = head_q;
      end
      if (push_ok_s) begin
        tail_d = tail_q + depth_log2'(1);
      end else begin
        tail_d = tail_q;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Set wins over a same-cycle clear.
    ovf_d = ovf_set_s || (ovf_q && !clr_ovf_s);
    udf_d = udf_set_s || (udf_q && !clr_udf_s);

    // Non-selected reads drive 0 so several peripherals can be OR-combined.
    if (rd_data_s) begin
      if (rd_first_s) begin
        if (empty_s) begin
          data_out_d = 8'h00;
        end else begin
          data_out_d = head_byte_s;
        end
      end else begin
        data_out_d = data_out_q;
      end
    end else begin
      data_out_d = 8'h00;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= {depth_log2{1'b0}};
      tail_q     <= {depth_log2{1'b0}};
      count_q    <= {CW{1'b0}};
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_prev_q  <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_prev_q  <= rd_prev_d;
      data_out_q <= data_out_d;
    end
  end

  // Status vector assembled from registered state only
  always_comb begin
    status_s                           = 8'h00;
    status_s[ST_NEMPTY]                = !empty_s;
    status_s[ST_FULL]                  = full_s;
    status_s[ST_OVF]                   = ovf_q;
    status_s[ST_UDF]                   = udf_q;
    status_s[ST_CNT_LSB +: 4]          = sat_cnt4(8'(count_q));
  end

  assign status   = status_s;
  assign data_out = data_out_q;

`ifdef ASRM_RX_FIFO_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt request follows registered occupancy/overflow one cycle later
  always_comb begin
    irq_d = !empty_s || ovf_q;
  end

  // Interrupt register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule : asrm_rx_fifo

// File: tb/tb_asrm_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_asrm_rx_fifo
// Directed bench for asrm_rx_fifo with a queue-based reference model compared
// against data_out/status (and irq when ASRM_RX_FIFO_IRQ_EN is defined) on
// every falling edge, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_asrm_rx_fifo;

  localparam int AW    = 16;
  localparam int BASE  = 16'h0100;
  localparam int DL2   = 3;
  localparam int DEPTH = 1 << DL2;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [AW-1:0] addr;
  logic          write_en;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          push;
  logic [7:0]    push_data;
  logic [7:0]    status;
`ifdef ASRM_RX_FIFO_IRQ_EN
  logic          irq;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  asrm_rx_fifo #(
    .addr_size  (AW),
    .base_addr  (BASE),
    .depth_log2 (DL2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .write_en  (write_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .push      (push),
    .push_data (push_data),
    .status    (status)
`ifdef ASRM_RX_FIFO_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  bit         m_ovf, m_udf, m_prev, m_irq;
  logic [7:0] m_dout;

  function automatic logic [7:0] exp_status();
    int n;
    n = q.size();
    return {4'((n > 15) ? 15 : n), m_udf, m_ovf, (n == DEPTH), (n != 0)};
  endfunction

  always @(posedge clk or negedge reset) begin
    bit rd, wc, first, popped, ovf_set, udf_set;
    if (!reset) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_prev = 0; m_irq = 0;
      m_dout = 8'h00;
    end else begin
      m_irq   = (q.size() != 0) || m_ovf;
      rd      = enable && !write_en && (addr == AW'(BASE));
      wc      = enable && write_en && (addr == AW'(BASE + 1));
      first   = rd && !m_prev;
      m_prev  = rd;
      popped  = 0; ovf_set = 0; udf_set = 0;
      if (rd && first) begin
        if (q.size() > 0) begin
          m_dout = q.pop_front();
          popped = 1;
        end else begin
          m_dout  = 8'h00;
          udf_set = 1;
        end
      end else if (!rd) begin
        m_dout = 8'h00;
      end
      if (wc && data_in[2]) begin
        q.delete();
      end else if (push) begin
        if (q.size() < DEPTH) q.push_back(push_data);
        else ovf_set = 1;
      end
      m_ovf = ovf_set || (m_ovf && !(wc && data_in[0]));
      m_udf = udf_set || (m_udf && !(wc && data_in[1]));
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dout", data_out, m_dout);
      check("model_status", status, exp_status());
`ifdef ASRM_RX_FIFO_IRQ_EN
      check("model_irq", {7'd0, irq}, {7'd0, m_irq});
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_bus();
    enable = 1'b0; write_en = 1'b0; addr = '0; data_in = 8'h00;
  endtask

  task automatic push_b(input logic [7:0] b);
    push = 1'b1; push_data = b;
    step();
    push = 1'b0; push_data = 8'h00;
  endtask

  // Read access held for n cycles; data_out must stay at exp throughout.
  task automatic rd_chk(input int n, input logic [7:0] exp);
    enable = 1'b1; write_en = 1'b0; addr = AW'(BASE);
    for (int i = 0; i < n; i++) begin
      step();
      check("rd_lit", data_out, exp);
    end
    idle_bus();
    step();
  endtask

  task automatic ctrl(input logic [7:0] v);
    enable = 1'b1; write_en = 1'b1; addr = AW'(BASE + 1); data_in = v;
    step();
    idle_bus();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; push = 1'b0; push_data = 8'h00;
    idle_bus();
    step(); step();
    chk_en = 1'b1;
    check("reset_status", status, 8'h00);
    check("reset_dout", data_out, 8'h00);
    reset = 1'b1;
    step();

    // Basic ordering
    push_b(8'h11); push_b(8'h22); push_b(8'h33);
    check("st_3", status, 8'h31);
    rd_chk(1, 8'h11); rd_chk(1, 8'h22); rd_chk(1, 8'h33);
    check("st_empty", status, 8'h00);

    // Overflow at depth 8
    for (int i = 1; i <= 9; i++) push_b(8'(i));
    check("st_ovf", status, 8'h87);
    for (int i = 1; i <= 8; i++) rd_chk(1, 8'(i));
    check("st_ovf_drained", status, 8'h04);
    ctrl(8'h01); step();
    check("st_clr_ovf", status, 8'h00);

    // Underflow
    rd_chk(1, 8'h00);
    check("st_udf", status, 8'h08);
    ctrl(8'h02); step();
    check("st_clr_udf", status, 8'h00);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_b(8'hB0 + 8'(i));
    check("st_full", status, 8'h83);
    enable = 1'b1; write_en = 1'b0; addr = AW'(BASE);
    push = 1'b1; push_data = 8'hAA;
    step();
    push = 1'b0; idle_bus();
    check("pp_dout", data_out, 8'hB0);
    check("pp_status", status, 8'h83);
    step();
    for (int i = 1; i < 8; i++) rd_chk(1, 8'hB0 + 8'(i));
    rd_chk(1, 8'hAA);
    check("st_pp_drained", status, 8'h00);

    // Held read pops once
    push_b(8'h5A); push_b(8'h6B);
    rd_chk(4, 8'h5A);
    check("st_held", status, 8'h11);
    rd_chk(1, 8'h6B);

    // Flush with simultaneous push
    for (int i = 0; i < 5; i++) push_b(8'h61 + 8'(i));
    check("st_5", status, 8'h51);
`ifdef ASRM_RX_FIFO_IRQ_EN
    check("irq_before", {7'd0, irq}, 8'h01);
`endif
    push = 1'b1; push_data = 8'h99;
    ctrl(8'h04);
    push = 1'b0;
    check("st_flush", status, 8'h00);
`ifdef ASRM_RX_FIFO_IRQ_EN
    check("irq_flush_edge", {7'd0, irq}, 8'h01);
`endif
    step();
`ifdef ASRM_RX_FIFO_IRQ_EN
    check("irq_after", {7'd0, irq}, 8'h00);
`endif
    rd_chk(1, 8'h00);
    check("st_flush_udf", status, 8'h08);
    ctrl(8'h02); step();

    // Empty with simultaneous push and pop
    enable = 1'b1; write_en = 1'b0; addr = AW'(BASE);
    push = 1'b1; push_data = 8'h77;
    step();
    push = 1'b0; idle_bus();
    check("ep_dout", data_out, 8'h00);
    check("ep_status", status, 8'h19);
    step();
    ctrl(8'h02); step();
    check("ep_clr", status, 8'h11);
    rd_chk(1, 8'h77);

    // Overflow set wins over same-cycle clear
    for (int i = 0; i < 8; i++) push_b(8'hC0 + 8'(i));
    push = 1'b1; push_data = 8'hCC;
    ctrl(8'h01);
    push = 1'b0;
    check("set_wins", status, 8'h87);
    ctrl(8'h05); step();
    check("st_flush_clr", status, 8'h00);

    // Reset in the middle of a read access
    push_b(8'h42);
    enable = 1'b1; write_en = 1'b0; addr = AW'(BASE);
    step();
    check("mid_dout", data_out, 8'h42);
    #2 reset = 1'b0;
    #1;
    check("rst_dout", data_out, 8'h00);
    check("rst_status", status, 8'h00);
    idle_bus();
    step();
    reset = 1'b1;
    step(); step();
    check("post_rst", status, 8'h00);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_asrm_rx_fifo

// File: doc/asrm_rx_fifo.md
Name: asrm_rx_fifo

Overview:
- Byte-wide receive FIFO peripheral sitting between a serial receiver (e.g. UART RX shift stage) and the system bus.
- Buffers incoming bytes and exposes a pop-on-read data register and a write-only control register.
- Drives an 8-bit status vector that feeds directly into the peripheral's read-only status register instance.

Parameters:
- addr_size, 16, width of system bus address.
- base_addr, 0, bus address of the DATA register; CTRL register sits at base_addr+1.
- depth_log2, 3, log2 of FIFO depth (default 8 entries; legal range 1..7).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  bus access strobe
- addr  input  addr_size  bus address
- write_en  input  1  bus write qualifier; 0 = read
- data_in  input  8  bus write data
- data_out  output  8  registered bus read data
- push  input  1  one-cycle strobe from receiver: byte valid
- push_data  input  8  received byte
- status  output  8  status vector to the status register

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named reset.
- Reset: pointers, count, sticky flags and data_out are 0; status = 0x00; storage contents are don't-care.
- Address decode:
  - rd_data = enable && !write_en && addr == base_addr.
  - wr_ctrl = enable && write_en && addr == base_addr+1.
- Read data path:
  - data_out is registered with one-cycle latency.
  - data_out = head byte when rd_data is active, else 0 (bus OR-combining convention).
  - Reading DATA while empty returns 0 and sets underflow.
- Pop timing: pop occurs only on the first cycle of a read access, i.e. rd_data high while rd_data was low last cycle. Holding enable for multiple cycles pops once; data_out holds the popped byte for the whole access.
- Push: on push with not full, store push_data at the tail and advance the tail.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - When full, the pop frees a slot and the push is accepted; overflow is not set.
  - When empty, the pop underflows (returns 0, underflow set) and the push is stored; count becomes 1.
- Overflow: push while full with no pop drops the byte, leaves the FIFO unchanged and sets sticky overflow.
- Pointers: depth_log2-bit head/tail wrap modulo depth; count is depth_log2+1 bits (0..depth).
- CTRL write:
  - data_in[0]=1 clears overflow.
  - data_in[1]=1 clears underflow.
  - data_in[2]=1 flushes: head=tail=count=0.
  - Flush takes priority over a same-cycle push or pop; the push is dropped and no overflow is set.
- status (combinational from registered state):
  - bit0 not_empty, bit1 full, bit2 overflow, bit3 underflow.
  - bits7:4 = count saturated at 15.
- Sticky set vs clear: if a flag is set and cleared in the same cycle, set wins.
- Reset mid-access: all state clears immediately; a pop in progress is lost and data_out is 0.

Optional Feature:
- Macro: ASRM_RX_FIFO_IRQ_EN.
- Defined: adds output irq (1 bit, registered, reset 0). irq = not_empty OR overflow, updated each cycle; it falls the cycle after the FIFO empties and overflow is cleared.
- Undefined: irq port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - Register offsets: DATA_OFS=0, CTRL_OFS=1.
  - Status bit indices: ST_NEMPTY=0, ST_FULL=1, ST_OVF=2, ST_UDF=3, ST_CNT_LSB=4.
  - CTRL bit indices: CT_CLR_OVF=0, CT_CLR_UDF=1, CT_FLUSH=2.
- Sub-module asrm_fifo_mem: 2^depth_log2 x 8 storage with synchronous write port and asynchronous read port. Pointer/flag control stays in asrm_rx_fifo.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 and read DATA 3x -> data_out 0x11, 0x22, 0x33 one cycle after each read; status goes 0x31 -> 0x00.
- Push 9 bytes 0x01..0x09 at depth 8 -> status = 0x87 (count 8, full, nempty, ovf); reads return 0x01..0x08; 0x09 is lost.
- Read DATA while empty -> data_out 0x00, status bit3 set; CTRL write 0x02 -> status 0x00.
- FIFO full, push 0xAA in the same cycle as a read pop -> no overflow, count stays 8; the last read after draining returns 0xAA.
- Hold enable on DATA read for 4 cycles with 2 bytes queued -> exactly one pop; data_out stable at the first byte; count 2 -> 1.
- 5 bytes queued, CTRL write 0x04 with a simultaneous push -> status 0x00; next read underflows. With ASRM_RX_FIFO_IRQ_EN: irq 1 before the flush, 0 the cycle after.
